// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit:
// operation codes, FSM states and small op classification helpers.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic op_signed(op_e o);
        return (o == MULT) || (o == DIV);
    endfunction

    function automatic logic op_is_div(op_e o);
        return (o == DIV) || (o == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned core: shift-add multiply step or
// restoring shift-subtract divide step on the {acc_hi, acc_lo} pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem  = {acc_hi, acc_lo[WIDTH-1]};
        diff = rem - {1'b0, opnd};
        nxt_hi = sum[WIDTH:1];
        nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            // Borrow out means the partial remainder was below the divisor
            if (diff[WIDTH]) begin
                nxt_hi = rem[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO,
// one bit per cycle on magnitudes followed by a sign fix-up cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hi_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e state, state_nxt;
    op_e    op_in, op_q;

    logic             sa_in, sb_in;
    logic             sa_q, sb_q;
    logic             div_q;
    logic [WIDTH-1:0] amag, bmag;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [CW-1:0]    cnt;
    logic             last, accept, mt_en;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign op_in  = op_e'(op);
    assign sa_in  = op_signed(op_in) && a[WIDTH-1];
    assign sb_in  = op_signed(op_in) && b[WIDTH-1];
    assign amag   = sa_in ? -a : a;
    assign bmag   = sb_in ? -b : b;
    assign div_q  = op_is_div(op_q);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state == IDLE) && start;
    assign mt_en  = (state == IDLE) && !start;
    assign result = hi_sel ? hi : lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = ITER;
            ITER: begin
                busy = 1'b1;
                if (last) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div(div_q),
        .acc_hi(acc_hi),
        .acc_lo(acc_lo),
        .opnd  (opnd),
        .nxt_hi(step_hi),
        .nxt_lo(step_lo)
    );

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (div_q) begin
            // |b| is zero only when b itself was zero
            if (opnd == '0) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_hi = sa_q ? -acc_hi : acc_hi;
                fix_lo = (sa_q ^ sb_q) ? -acc_lo : acc_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= MULT;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            a_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (accept) begin
                op_q   <= op_in;
                sa_q   <= sa_in;
                sb_q   <= sb_in;
                a_q    <= a;
                acc_hi <= '0;
                acc_lo <= op_is_div(op_in) ? amag : bmag;
                opnd   <= op_is_div(op_in) ? bmag : amag;
                cnt    <= '0;
            end
            if (mt_en && mthi) hi <= wdata;
            if (mt_en && mtlo) lo <= wdata;
            if (state == ITER) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= last ? '0 : cnt + 1'b1;
            end
            if (state == FIX) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every
// cycle plus directed vectors with literal HI/LO expectations.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic [1:0]   op     = 2'b00;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         mthi   = 1'b0;
    logic         mtlo   = 1'b0;
    logic [W-1:0] wdata  = '0;
    logic         hi_sel = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo, result;

    int total  = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic [W-1:0] exp_hi   = '0;
    logic [W-1:0] exp_lo   = '0;
    logic [2*W-1:0] pend   = '0;
    int           remaining = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .hi_sel(hi_sel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .result(result)
    );

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // {HI,LO} straight from the arithmetic definition of each op
    function automatic logic [2*W-1:0] spec_result(
        input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, sq, sr;
        logic [2*W-1:0] p;
        logic [W-1:0] uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            2'b00: begin
                sq = sx * sy;
                p  = sq;
            end
            2'b01: p = {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == '0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    p  = {sr[W-1:0], sq[W-1:0]};
                end
            end
            default: begin
                if (y == '0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    uq = x / y;
                    ur = x % y;
                    p  = {ur, uq};
                end
            end
        endcase
        return p;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_busy  <= 1'b0;
            exp_done  <= 1'b0;
            exp_hi    <= '0;
            exp_lo    <= '0;
            remaining <= 0;
        end else begin
            exp_done <= 1'b0;
            if (!exp_busy) begin
                if (start) begin
                    pend      <= spec_result(op, a, b);
                    exp_busy  <= 1'b1;
                    remaining <= W;
                end else begin
                    if (mthi) exp_hi <= wdata;
                    if (mtlo) exp_lo <= wdata;
                end
            end else if (remaining == 0) begin
                exp_hi   <= pend[2*W-1:W];
                exp_lo   <= pend[W-1:0];
                exp_busy <= 1'b0;
                exp_done <= 1'b1;
            end else begin
                remaining <= remaining - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc busy", 32'(busy), 32'(exp_busy));
            chk("cyc done", 32'(done), 32'(exp_done));
            chk("cyc hi", hi, exp_hi);
            chk("cyc lo", lo, exp_lo);
            chk("cyc result", result, hi_sel ? exp_hi : exp_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string nm, input int lat);
        int k;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
        chk({nm, " latency"}, 32'(k), 32'(lat));
    endtask

    task automatic do_op(input string nm, input logic [1:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nm, 33);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        do_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult -7*3", 2'b00, 32'hFFFF_FFF9, 32'd3,
              32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD);
        do_op("divu 100/0", 2'b11, 32'd100, 32'd0,
              32'd100, 32'hFFFF_FFFF);
        do_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0,
              32'hFFFF_FFFB, 32'hFFFF_FFFF);
        do_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000);
        do_op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'd0);
        do_op("divu max/1", 2'b11, 32'hFFFF_FFFF, 32'd1,
              32'd0, 32'hFFFF_FFFF);
        do_op("divu 1000/7", 2'b11, 32'd1000, 32'd7,
              32'd6, 32'd142);

        op    = 2'b00;
        a     = 32'hFFFF_FFF9;
        b     = 32'd3;
        start = 1'b1;
        tick();
        op    = 2'b01;
        a     = 32'd5;
        b     = 32'd9;
        mthi  = 1'b1;
        wdata = 32'hAAAA_5555;
        repeat (3) tick();
        start = 1'b0;
        mthi  = 1'b0;
        wait_done("busy ignore", 30);
        chk("busy ignore hi", hi, 32'hFFFF_FFFF);
        chk("busy ignore lo", lo, 32'hFFFF_FFEB);

        mtlo   = 1'b1;
        wdata  = 32'h1234_5678;
        hi_sel = 1'b0;
        tick();
        mtlo = 1'b0;
        chk("mtlo lo", lo, 32'h1234_5678);
        chk("mtlo result", result, 32'h1234_5678);

        mthi   = 1'b1;
        wdata  = 32'hCAFE_F00D;
        hi_sel = 1'b1;
        tick();
        mthi = 1'b0;
        chk("mthi hi", hi, 32'hCAFE_F00D);
        chk("mthi result", result, 32'hCAFE_F00D);
        hi_sel = 1'b0;

        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        mtlo  = 1'b0;
        wait_done("start+mtlo", 33);
        chk("start+mtlo hi", hi, 32'd0);
        chk("start+mtlo lo", lo, 32'd15);

        mthi  = 1'b1;
        wdata = 32'h0000_0055;
        tick();
        mthi = 1'b0;

        op    = 2'b11;
        a     = 32'd1000;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        do_op("after reset", 2'b10, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 SHALL have op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have a  input  WIDTH  multiplicand/dividend.
REQ-007 SHALL have b  input  WIDTH  multiplier/divisor.
REQ-008 SHALL have mthi  input  1  write wdata into HI.
REQ-009 SHALL have mtlo  input  1  write wdata into LO.
REQ-010 SHALL have wdata  input  WIDTH  data for mthi/mtlo.
REQ-011 SHALL have hi_sel  input  1  1 selects HI, 0 selects LO onto result.
REQ-012 SHALL have busy  output  1  operation in progress.
REQ-013 SHALL have done  output  1  one-cycle pulse, HI/LO just updated by an operation.
REQ-014 SHALL have hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-015 SHALL have result  output  WIDTH  combinational hi_sel?hi:lo; feeds the writeback select's reserved input 11 (MFHI/MFLO).

Function
REQ-016 SHALL implement FSM states IDLE, ITER, FIX; reset state IDLE.
REQ-017 IDLE: start=1 at edge N latches op, |a|, |b| (magnitudes for signed ops, raw for unsigned), sign flags; next state ITER, busy=1 from N.
REQ-018 ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, iteration counter 0..WIDTH-1; after WIDTH steps go to FIX.
REQ-019 FIX: apply sign correction, write HI/LO at that edge (edge N+WIDTH+1), go to IDLE; busy=0 and done=1 for exactly the following cycle.
REQ-020 Total latency: start accepted at edge N, HI/LO valid and done=1 after edge N+WIDTH+1 (33 cycles for WIDTH=32).
REQ-021 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product, two's-complement for MULT.
REQ-022 DIV/DIVU: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend's sign.
REQ-023 Divide by zero: same latency, LO = all ones, HI = a (dividend, unmodified).
REQ-024 DIV of most-negative by -1: LO = 0x80000000, HI = 0 (WIDTH=32).
REQ-025 start while busy=1 SHALL be ignored; operands/op changes while busy SHALL not affect the result.
REQ-026 mthi/mtlo while busy=0 SHALL write HI/LO at the next edge; while busy=1 SHALL be ignored.
REQ-027 start and mthi/mtlo in the same IDLE cycle: start wins, the write is dropped.
REQ-028 hi/lo SHALL hold their previous values throughout ITER; updated only in FIX or by mthi/mtlo.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, independent of clk.
REQ-030 reset during ITER/FIX SHALL abort the operation; no done pulse for it; start is accepted on first edge after reset deasserts.

Structure
REQ-031 Shared package SHALL hold op encodings (MULT, MULTU, DIV, DIVU) and the FSM state encoding.
REQ-032 One combinational sub-module muldiv_step SHALL compute a single multiply or divide iteration; instantiated once.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done one cycle.
REQ-034 MULT a=-7 b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=-7 b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-035 DIVU a=100 b=0 -> LO=0xFFFFFFFF, HI=100, latency 33; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-036 start during busy with different operands, mthi=1 during busy -> ignored; original result and HI intact.
REQ-037 mtlo wdata=0x12345678, hi_sel=0 -> next cycle lo and result = 0x12345678; same cycle as start -> write dropped.
REQ-038 reset asserted mid-ITER (cycle 10) -> busy=0, hi=lo=0 immediately, no done; new start afterward completes normally.
